counter_updown_mod: RTL and testbench

- Parametrised successor to the fixed 4-bit enable counter.
- Generalised width, runtime modulo limit, up/down direction, synchronous load and clear, and a build-time wrap or saturate mode.
- Terminal-count pulse and sticky overflow flag.
- Used as the standard event/timer counter in datapath and testbench-visible control logic.

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_updown_mod.sv | 66 ++++++
 tb/tb_counter_updown_mod.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: direction encoding and
// build-time limit behaviour selectors.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/counter_updown_mod.sv
// Parametrised up/down event counter with runtime inclusive limit, synchronous
// clear/load, wrap-or-saturate limit handling, terminal-count pulse and sticky ovf.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_limit;

  // Up direction uses >= so a count loaded above max_val still counts as a limit.
  always_comb begin
    at_limit = (up == DIR_UP) ? (count_q >= max_val) : (count_q == '0);
    count_d  = count_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (enable) begin
      tc_d  = at_limit;
      ovf_d = ovf_q | at_limit;
      if (!at_limit) begin
        count_d = (up == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
      end else if (SATURATE == MODE_WRAP) begin
        count_d = (up == DIR_UP) ? '0 : max_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(RESET_VAL);
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule : counter_updown_mod

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: a wrap and a saturate instance share stimulus and
// are checked every cycle against an integer reference model plus literal checks.
module tb_counter_updown_mod;
  import counter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, clear, load, up;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, tc_s, ovf_w, ovf_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_cnt [2];
  int m_tc  [2];
  int m_ovf [2];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(W), .RESET_VAL(0), .SATURATE(MODE_WRAP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .up(up), .max_val(max_val),
    .count(cnt_w), .tc(tc_w), .ovf(ovf_w)
  );

  counter_updown_mod #(.WIDTH(W), .RESET_VAL(0), .SATURATE(MODE_SAT)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .up(up), .max_val(max_val),
    .count(cnt_s), .tc(tc_s), .ovf(ovf_s)
  );

  // Reference rules stated directly on integers.
  function automatic void model_step(input bit sat, input int c, input int o,
                                     output int nc, output int nt, output int no);
    int mx;
    bit lim;
    mx = int'(max_val);
    nc = c; nt = 0; no = o;
    if (clear) begin
      nc = 0; no = 0;
    end else if (load) begin
      nc = int'(load_val);
    end else if (enable) begin
      lim = up ? (c >= mx) : (c == 0);
      if (lim) begin
        nt = 1; no = 1;
        if (!sat) nc = up ? 0 : mx;
      end else begin
        nc = up ? c + 1 : c - 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] <= 0; m_tc[k] <= 0; m_ovf[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int nc, nt, no;
        model_step(k == 1, m_cnt[k], m_ovf[k], nc, nt, no);
        m_cnt[k] <= nc; m_tc[k] <= nt; m_ovf[k] <= no;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wrap.count", int'(cnt_w), m_cnt[0]);
      chk("wrap.tc",    int'(tc_w),  m_tc[0]);
      chk("wrap.ovf",   int'(ovf_w), m_ovf[0]);
      chk("sat.count",  int'(cnt_s), m_cnt[1]);
      chk("sat.tc",     int'(tc_s),  m_tc[1]);
      chk("sat.ovf",    int'(ovf_s), m_ovf[1]);
    end
  end

  // Drive one cycle of controls, then land 2 time units after the edge.
  task automatic step(input logic en, input logic clr, input logic ld,
                      input logic [W-1:0] lv, input logic u);
    enable = en; clear = clr; load = ld; load_val = lv; up = u;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_up [12];
    int exp_dn [4];
    int exp_sat [5];
    exp_up  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_dn  = '{1, 0, 9, 8};
    exp_sat = '{8, 9, 9, 9, 9};

    rst_n = 1'b0; enable = 0; clear = 0; load = 0; load_val = '0; up = DIR_UP; max_val = 4'd9;
    #1;
    chk("reset.count", int'(cnt_w), 0);
    chk("reset.tc",    int'(tc_w),  0);
    chk("reset.ovf",   int'(ovf_w), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: asynchronous reset mid-count
    repeat (5) step(1, 0, 0, '0, DIR_UP);
    chk("t1.count5", int'(cnt_w), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("t1.async.count", int'(cnt_w), 0);
    chk("t1.async.tc",    int'(tc_w),  0);
    chk("t1.async.ovf",   int'(ovf_w), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, '0, DIR_UP);
    chk("t1.resume", int'(cnt_w), 1);

    // 2: up wrap
    step(0, 1, 0, '0, DIR_UP);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, '0, DIR_UP);
      chk("t2.count", int'(cnt_w), exp_up[i]);
      chk("t2.tc",    int'(tc_w),  (i == 9) ? 1 : 0);
      chk("t2.ovf",   int'(ovf_w), (i >= 9) ? 1 : 0);
    end

    // 3: down wrap
    step(0, 0, 1, 4'd2, DIR_UP);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, '0, DIR_DOWN);
      chk("t3.count", int'(cnt_w), exp_dn[i]);
      chk("t3.tc",    int'(tc_w),  (i == 2) ? 1 : 0);
    end
    chk("t3.ovf", int'(ovf_w), 1);

    // 4: saturate
    step(0, 1, 0, '0, DIR_UP);
    step(0, 0, 1, 4'd7, DIR_UP);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, '0, DIR_UP);
      chk("t4.count", int'(cnt_s), exp_sat[i]);
      chk("t4.tc",    int'(tc_s),  (i >= 2) ? 1 : 0);
    end
    chk("t4.ovf", int'(ovf_s), 1);

    // 5: priority
    step(1, 1, 1, 4'd5, DIR_UP);
    chk("t5.clr.count", int'(cnt_w), 0);
    chk("t5.clr.ovf",   int'(ovf_w), 0);
    chk("t5.clr.ovf_s", int'(ovf_s), 0);
    step(1, 0, 1, 4'd5, DIR_UP);
    chk("t5.load", int'(cnt_w), 5);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, '0, DIR_UP);
      chk("t5.hold.count", int'(cnt_w), 5);
      chk("t5.hold.tc",    int'(tc_w),  0);
    end

    // 6: loaded above the limit
    step(0, 0, 1, 4'd12, DIR_UP);
    step(1, 0, 0, '0, DIR_UP);
    chk("t6.wrap.count", int'(cnt_w), 0);
    chk("t6.wrap.tc",    int'(tc_w),  1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1, 0, 0, '0, DIR_UP);
      chk("t6.sat.count", int'(cnt_s), 12);
      chk("t6.sat.tc",    int'(tc_s),  1);
    end

    // max_val = 0 corner
    max_val = '0;
    step(0, 1, 0, '0, DIR_UP);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, '0, (i == 2) ? DIR_DOWN : DIR_UP);
      chk("mx0.count", int'(cnt_w), 0);
      chk("mx0.tc",    int'(tc_w),  1);
    end

    // Randomised run; occasional asynchronous reset pulses between edges
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) max_val = W'($urandom_range(0, 15));
      enable   = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = W'($urandom_range(0, 15));
      up       = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 79) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_counter_updown_mod
